multi_channel_gain_corrector: RTL

MULTI_CHANNEL_GAIN_CORRECTOR -- requirements
Module: multi_channel_gain_corrector

---
 rtl/multi_channel_gain_corrector_if.sv | 27 ++
 rtl/multi_channel_gain_corrector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_gain_corrector_if.sv
// AXI4-Stream bundle used for the video ports of multi_channel_gain_corrector.
// tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic                  tuser;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/multi_channel_gain_corrector.sv
// Per-channel video gain with frame-synchronous coefficient updates, 2-stage pipeline.
// Optional macro GAIN_RAMP_EN: step gains toward the target by at most RAMP_STEP per frame.
module multi_channel_gain_corrector #(
  parameter int PX_WIDTH    = 10,
  parameter int CHANNELS    = 3,
  parameter int FRACT_WIDTH = 10,
  parameter int RAMP_STEP   = 64,
  parameter int ID_WIDTH    = 4,
  parameter int DEST_WIDTH  = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  axi4_stream_if.slave                                video_i,
  axi4_stream_if.master                               video_o,
  input  logic [CHANNELS*(PX_WIDTH+FRACT_WIDTH)-1:0]  coef_i,
  input  logic                                        coef_valid_i,
  input  logic                                        bypass_i,
  output logic [CHANNELS*(PX_WIDTH+FRACT_WIDTH)-1:0]  cur_coef_o,
  output logic                                        update_pending_o
);
  localparam int COEF_WIDTH  = PX_WIDTH + FRACT_WIDTH;
  localparam int PROD_WIDTH  = 2 * COEF_WIDTH;
  localparam int TDATA_WIDTH = ((CHANNELS * PX_WIDTH + 7) / 8) * 8;
  localparam int KEEP_WIDTH  = TDATA_WIDTH / 8;

  localparam logic [COEF_WIDTH-1:0]   UNITY = COEF_WIDTH'(1) << FRACT_WIDTH;
  localparam logic [PROD_WIDTH:0]     HALF  = (PROD_WIDTH+1)'(1) << (FRACT_WIDTH - 1);
  localparam logic [PROD_WIDTH:0]     PXMAX = {{(PROD_WIDTH+1-PX_WIDTH){1'b0}}, {PX_WIDTH{1'b1}}};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] APPLY   = 2'd2;

  logic [1:0]                           r_state;
  logic [CHANNELS-1:0][COEF_WIDTH-1:0]  r_active;
  logic [CHANNELS-1:0][COEF_WIDTH-1:0]  r_target;
  logic [CHANNELS-1:0][COEF_WIDTH-1:0]  w_coef_req;
  logic [CHANNELS-1:0][COEF_WIDTH-1:0]  w_active_nxt;
  logic [CHANNELS-1:0][COEF_WIDTH-1:0]  w_gain_p0;
  logic [CHANNELS-1:0][PROD_WIDTH-1:0]  w_prod_p0;

  logic                                 r_vld_p1;
  logic [CHANNELS-1:0][PROD_WIDTH-1:0]  r_prod_p1;
  logic                                 r_last_p1, r_user_p1;
  logic [KEEP_WIDTH-1:0]                r_strb_p1, r_keep_p1;
  logic [ID_WIDTH-1:0]                  r_id_p1;
  logic [DEST_WIDTH-1:0]                r_dest_p1;

  logic                                 r_vld_p2;
  logic [TDATA_WIDTH-1:0]               r_data_p2;
  logic                                 r_last_p2, r_user_p2;
  logic [KEEP_WIDTH-1:0]                r_strb_p2, r_keep_p2;
  logic [ID_WIDTH-1:0]                  r_id_p2;
  logic [DEST_WIDTH-1:0]                r_dest_p2;
  logic [TDATA_WIDTH-1:0]               w_data_p1;

  logic w_rdy_p1, w_rdy_p2, w_acc_p0, w_sof_acc, w_apply;

  function automatic logic [PX_WIDTH-1:0] round_sat(input logic [PROD_WIDTH-1:0] prod);
    logic [PROD_WIDTH:0] sum;
    sum = ({1'b0, prod} + HALF) >> FRACT_WIDTH;
    if (sum > PXMAX) round_sat = {PX_WIDTH{1'b1}};
    else             round_sat = sum[PX_WIDTH-1:0];
  endfunction

`ifdef GAIN_RAMP_EN
  localparam logic [COEF_WIDTH-1:0] STEP = COEF_WIDTH'(RAMP_STEP);

  function automatic logic [COEF_WIDTH-1:0] ramp_step(input logic [COEF_WIDTH-1:0] act,
                                                      input logic [COEF_WIDTH-1:0] tgt);
    if (tgt > act) ramp_step = ((tgt - act) > STEP) ? act + STEP : tgt;
    else           ramp_step = ((act - tgt) > STEP) ? act - STEP : tgt;
  endfunction
`endif

  assign w_coef_req = coef_i;
  assign w_rdy_p2   = !r_vld_p2 || video_o.tready;
  assign w_rdy_p1   = !r_vld_p1 || w_rdy_p2;
  assign w_acc_p0   = video_i.tvalid && w_rdy_p1;
  assign w_sof_acc  = w_acc_p0 && video_i.tuser;
  // In IDLE active already equals target, so only PENDING/APPLY move the gain.
  assign w_apply    = w_sof_acc && (r_state != IDLE);

  always_comb begin
    w_active_nxt = r_active;
    if (w_apply) begin
`ifdef GAIN_RAMP_EN
      for (int k = 0; k < CHANNELS; k++) w_active_nxt[k] = ramp_step(r_active[k], r_target[k]);
`else
      w_active_nxt = r_target;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_active <= {CHANNELS{UNITY}};
      r_target <= {CHANNELS{UNITY}};
    end else begin
      r_active <= w_active_nxt;
      if (coef_valid_i) begin
        r_target <= w_coef_req;
        r_state  <= PENDING;
      end else begin
        case (r_state)
          PENDING: if (w_sof_acc) r_state <= APPLY;
          APPLY:   if (r_active == r_target) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Stage 0 -> 1: multiply at full precision; the SOF beat already sees the new gain.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_gain_p0[k] = bypass_i ? UNITY : w_active_nxt[k];
      w_prod_p0[k] = PROD_WIDTH'(video_i.tdata[k*PX_WIDTH +: PX_WIDTH]) * PROD_WIDTH'(w_gain_p0[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)         r_vld_p1 <= 1'b0;
    else if (w_rdy_p1) r_vld_p1 <= video_i.tvalid;
  end

  always_ff @(posedge clk_i) begin
    if (w_acc_p0) begin
      r_prod_p1 <= w_prod_p0;
      r_last_p1 <= video_i.tlast;
      r_user_p1 <= video_i.tuser;
      r_strb_p1 <= video_i.tstrb;
      r_keep_p1 <= video_i.tkeep;
      r_id_p1   <= video_i.tid;
      r_dest_p1 <= video_i.tdest;
    end
  end

  // Stage 1 -> 2: round half up, saturate, zero the padding bits.
  always_comb begin
    w_data_p1 = '0;
    for (int k = 0; k < CHANNELS; k++) w_data_p1[k*PX_WIDTH +: PX_WIDTH] = round_sat(r_prod_p1[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_last_p2 <= 1'b0;
      r_user_p2 <= 1'b0;
      r_strb_p2 <= '0;
      r_keep_p2 <= '0;
      r_id_p2   <= '0;
      r_dest_p2 <= '0;
    end else if (w_rdy_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_data_p1;
        r_last_p2 <= r_last_p1;
        r_user_p2 <= r_user_p1;
        r_strb_p2 <= r_strb_p1;
        r_keep_p2 <= r_keep_p1;
        r_id_p2   <= r_id_p1;
        r_dest_p2 <= r_dest_p1;
      end
    end
  end

  assign video_i.tready   = w_rdy_p1;
  assign video_o.tvalid   = r_vld_p2;
  assign video_o.tdata    = r_data_p2;
  assign video_o.tlast    = r_last_p2;
  assign video_o.tuser    = r_user_p2;
  assign video_o.tstrb    = r_strb_p2;
  assign video_o.tkeep    = r_keep_p2;
  assign video_o.tid      = r_id_p2;
  assign video_o.tdest    = r_dest_p2;
  assign cur_coef_o       = r_active;
  assign update_pending_o = (r_state != IDLE);

endmodule
